// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK demodulator: FSM state encoding and the
// accumulator width rule used by the top and the integrate-and-dump stage.
package bpsk_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INTEGRATE = 2'd1,
        DUMP      = 2'd2
    } bpsk_state_e;

    // Full product width plus enough guard bits to sum one whole symbol.
    function automatic int acc_width(input int sample_w, input int samples_per_symbol);
        return 2 * sample_w + $clog2(samples_per_symbol) + 1;
    endfunction

endpackage

// File: rtl/bpsk_integrate_dump.sv
// Multiply-accumulate for one symbol: signed sample x carrier, full precision,
// loaded on the first sample of a symbol and summed on the rest.
module bpsk_integrate_dump #(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 38
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic [SAMPLE_W-1:0] i_carrier,
    input  logic                i_valid,
    input  logic                i_load,
    output logic [ACC_W-1:0]    o_acc
);

    logic signed [2*SAMPLE_W-1:0] w_prod;
    logic        [ACC_W-1:0]      w_prod_ext;
    logic        [ACC_W-1:0]      r_acc;

    assign w_prod     = $signed(i_sample) * $signed(i_carrier);
    assign w_prod_ext = {{(ACC_W-2*SAMPLE_W){w_prod[2*SAMPLE_W-1]}}, w_prod};

    // Loading on the first sample lets back-to-back symbols integrate with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_valid) begin
            r_acc <= i_load ? w_prod_ext : r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/bpsk_demodulator_top.sv
// Coherent BPSK demodulator: carrier phase/sample counters, aligned MAC and a
// sign decision per symbol. Define BPSK_DEMOD_DIFF_EN for differential output.
`ifndef FIXDT_64_A_WIDTH
`define FIXDT_64_A_WIDTH 16
`endif
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 8
`endif

module bpsk_demodulator_top
    import bpsk_pkg::*;
#(
    parameter int SYMBOL_PERIODS = 4
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           en,
    input  logic [`FIXDT_64_A_WIDTH-1:0]                   in,
    output logic [$clog2(`CARRIER_SAMPLES_PER_PERIOD)-1:0] cosine_lu,
    input  logic [`FIXDT_64_A_WIDTH-1:0]                   carrier,
    output logic                                           out,
    output logic                                           out_valid,
    output logic [1:0]                                     o_dbg_state
);

    localparam int SAMPLES_PER_SYMBOL = SYMBOL_PERIODS * `CARRIER_SAMPLES_PER_PERIOD;
    localparam int W     = `FIXDT_64_A_WIDTH;
    localparam int CSPP  = `CARRIER_SAMPLES_PER_PERIOD;
    localparam int PH_W  = $clog2(CSPP);
    localparam int SC_W  = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
    localparam int ACC_W = acc_width(W, SAMPLES_PER_SYMBOL);

    // en qualifies in for exactly one cycle (no back-pressure); out_valid is a
    // one-cycle pulse and out holds its value between pulses.
    logic [PH_W-1:0]  r_ph;
    logic [SC_W-1:0]  r_sc;
    logic [W-1:0]     r_sample;
    logic             r_valid;
    logic             r_load;
    logic             r_last;
    bpsk_state_e      r_state;
    logic             r_out;
    logic             r_out_valid;
    logic [ACC_W-1:0] w_acc;
    logic             w_last_acc;
    logic             w_decision;
`ifdef BPSK_DEMOD_DIFF_EN
    logic             r_prev_dec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph <= '0;
            r_sc <= '0;
        end else if (en) begin
            r_ph <= (r_ph == PH_W'(CSPP-1)) ? '0 : r_ph + PH_W'(1);
            r_sc <= (r_sc == SC_W'(SAMPLES_PER_SYMBOL-1)) ? '0 : r_sc + SC_W'(1);
        end
    end

    assign cosine_lu = r_ph;

    // The LUT answers one cycle after cosine_lu, so the sample waits one cycle too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_load   <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            r_valid <= en;
            if (en) begin
                r_sample <= in;
                r_load   <= (r_sc == '0);
                r_last   <= (r_sc == SC_W'(SAMPLES_PER_SYMBOL-1));
            end
        end
    end

    bpsk_integrate_dump #(
        .SAMPLE_W (W),
        .ACC_W    (ACC_W)
    ) u_integrate_dump (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_sample  (r_sample),
        .i_carrier (carrier),
        .i_valid   (r_valid),
        .i_load    (r_load),
        .o_acc     (w_acc)
    );

    assign w_last_acc = r_valid & r_last;
    assign w_decision = ~w_acc[ACC_W-1] & (|w_acc);

    // DUMP reads the finished sum while the next symbol may already be loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef BPSK_DEMOD_DIFF_EN
            r_prev_dec  <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) r_state <= INTEGRATE;
                end
                INTEGRATE: begin
                    if (w_last_acc) r_state <= DUMP;
                end
                DUMP: begin
                    r_state     <= (en || r_valid) ? INTEGRATE : IDLE;
                    r_out_valid <= 1'b1;
`ifdef BPSK_DEMOD_DIFF_EN
                    r_out       <= w_decision ^ r_prev_dec;
                    r_prev_dec  <= w_decision;
`else
                    r_out       <= w_decision;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out         = r_out;
    assign out_valid   = r_out_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bpsk_demodulator_top.sv
// Randomized bench for bpsk_demodulator_top: a per-symbol correlation model
// predicts each decision bit and the cycle of its out_valid pulse.
`ifndef FIXDT_64_A_WIDTH
`define FIXDT_64_A_WIDTH 16
`endif
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 8
`endif

module tb_bpsk_demodulator_top;
  import bpsk_pkg::*;

  localparam int W     = `FIXDT_64_A_WIDTH;
  localparam int CSPP  = `CARRIER_SAMPLES_PER_PERIOD;
  localparam int SYM_P = 4;
  localparam int SPS   = SYM_P * CSPP;
  localparam int SMAX  = (1 << (W - 1)) - 1;
  localparam int SMIN  = -(1 << (W - 1));
  localparam real PI   = 3.14159265358979323846;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [W-1:0] in_s;
  logic [$clog2(CSPP)-1:0] cosine_lu;
  logic [W-1:0] carrier = '0;
  logic out;
  logic out_valid;
  logic [1:0] o_dbg_state;

  always #5 clk = ~clk;

  bpsk_demodulator_top #(.SYMBOL_PERIODS(SYM_P)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .in          (in_s),
    .cosine_lu   (cosine_lu),
    .carrier     (carrier),
    .out         (out),
    .out_valid   (out_valid),
    .o_dbg_state (o_dbg_state)
  );

  int cos_tab[CSPP];
  int cyc = 0;

  // Shared cosine LUT: registered read port.
  always @(posedge clk) carrier <= W'(cos_tab[cosine_lu]);
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [0:0] exp_q[$];
  int         exp_cyc_q[$];
  int         m_n;
  longint     m_sum;
  bit         m_prev;

  task automatic model_reset();
    m_n = 0;
    m_sum = 0;
    m_prev = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  // Correlate against the ideal carrier; the decision is the sign of the sum.
  task automatic model_push(input int v);
    bit b;
    m_sum += longint'(v) * longint'(cos_tab[m_n % CSPP]);
    if ((m_n % SPS) == SPS - 1) begin
      b = (m_sum > 0);
`ifdef BPSK_DEMOD_DIFF_EN
      exp_q.push_back(b ^ m_prev);
      m_prev = b;
`else
      exp_q.push_back(b);
`endif
      exp_cyc_q.push_back(cyc + 3);
      m_sum = 0;
    end
    m_n++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_sample(input bit e, input int v);
    logic signed [W-1:0] s;
    @(posedge clk);
    #1;
    s = v[W-1:0];
    en = e;
    in_s = s;
    if (e) model_push(int'(s));
  endtask

  function automatic int gen(input bit b, input int amp, input int nz, input int ph);
    int v;
    v = (amp * cos_tab[ph]) / SMAX;
    if (!b) v = -v;
    if (nz > 0) v += int'($urandom_range(0, 2 * nz)) - nz;
    if (v > SMAX) v = SMAX;
    if (v < SMIN) v = SMIN;
    return v;
  endfunction

  // mode 0: continuous en, 1: en alternates 1/0, 2: random idle gaps
  task automatic send_symbol(input bit b, input int amp, input int nz, input int mode);
    for (int k = 0; k < SPS; k++) begin
      if (mode == 2) while ($urandom_range(0, 3) == 0) drive_sample(1'b0, int'($urandom));
      drive_sample(1'b1, gen(b, amp, nz, m_n % CSPP));
      if (mode == 1) drive_sample(1'b0, int'($urandom));
    end
  endtask

  task automatic send_pattern(input int kind);
    int v;
    int c;
    for (int k = 0; k < SPS; k++) begin
      c = cos_tab[m_n % CSPP];
      case (kind)
        0: v = SMIN;
        1: v = (c > 0) ? SMAX : ((c < 0) ? SMIN : 0);
        2: v = (k == 0) ? 1 : 0;
        3: v = (k == 2) ? 1 : 0;
        4: v = (k == 0) ? -1 : 0;
        default: v = int'($urandom_range(0, 2 * SMAX + 1)) + SMIN;
      endcase
      drive_sample(1'b1, v);
    end
  endtask

  task automatic drain();
    drive_sample(1'b0, 0);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    check("drain_pending", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic       held_out;
  logic [1:0] prev_state;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_out   <= 1'b0;
      prev_state <= IDLE;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_pulse", out_valid, 0);
        end else begin
          check("out_bit", out, exp_q[0]);
          check("pulse_cycle", cyc, exp_cyc_q[0]);
          exp_q.delete(0);
          exp_cyc_q.delete(0);
        end
        check("dump_state", prev_state, DUMP);
        held_out <= out;
      end else begin
        check("out_hold", out, held_out);
      end
      prev_state <= o_dbg_state;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit b;
    for (int i = 0; i < CSPP; i++)
      cos_tab[i] = int'($floor(real'(SMAX) * $cos(2.0 * PI * real'(i) / real'(CSPP)) + 0.5));
    model_reset();
    rst_n = 1'b0;
    en = 1'b0;
    in_s = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_lu", cosine_lu, 0);
    check("rst_state", o_dbg_state, IDLE);
    #1 rst_n = 1'b1;

    // loopback pattern 1,0,1,1,0 with clean modulated carrier
    send_symbol(1'b1, 20000, 0, 0);
    send_symbol(1'b0, 20000, 0, 0);
    send_symbol(1'b1, 20000, 0, 0);
    send_symbol(1'b1, 20000, 0, 0);
    send_symbol(1'b0, 20000, 0, 0);
    // constant zero: two symbols decode to 0
    send_symbol(1'b1, 0, 0, 0);
    send_symbol(1'b1, 0, 0, 0);
    drain();

    // boundaries: zero-sum, max magnitude, smallest nonzero sums
    for (int k = 0; k < 5; k++) send_pattern(k);
    drain();

    // en toggling each cycle, same bit pattern
    send_symbol(1'b1, 20000, 0, 1);
    send_symbol(1'b0, 20000, 0, 1);
    send_symbol(1'b1, 20000, 0, 1);
    send_symbol(1'b1, 20000, 0, 1);
    send_symbol(1'b0, 20000, 0, 1);
    drain();

    // random bits, amplitudes, noise and gaps
    for (int s = 0; s < 20; s++) begin
      b = 1'($urandom_range(0, 1));
      send_symbol(b, int'($urandom_range(500, SMAX)), int'($urandom_range(0, 20000)),
                  int'($urandom_range(0, 2)));
    end
    for (int s = 0; s < 4; s++) send_pattern(9);
    drain();

    // reset in the middle of a symbol
    for (int k = 0; k < SPS / 2; k++) drive_sample(1'b1, gen(1'b1, 20000, 0, m_n % CSPP));
    drive_sample(1'b0, 0);
    #1 check("mid_state", o_dbg_state, INTEGRATE);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_lu", cosine_lu, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_out", out, 0);
    check("mid_rst_state", o_dbg_state, IDLE);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    send_symbol(1'b0, 15000, 3000, 0);
    send_symbol(1'b1, 15000, 3000, 0);
    send_symbol(1'b1, 15000, 3000, 2);
    send_symbol(1'b0, 15000, 3000, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(600000);
    $display("FAIL watchdog: simulation did not finish, time %0t limit 600000", $time);
    $fatal(1);
  end

endmodule
